// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: 2-flop power-good sync, debounce, then one stage released every STAGE_DELAY cycles.
// RST_SEQ_REVERSE_EN: shutdown re-asserts stages top-down DOWN_DELAY apart; otherwise all stages drop on one edge.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int COUNT_WIDTH = 24,
    parameter int STAGE_DELAY = 5000000,
    parameter int DOWN_DELAY  = 50000
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  pwr_good,
    input  logic                  force_rst,
    output logic [NUM_STAGES-1:0] rst_out_l,
    output logic                  seq_done,
    output logic [1:0]            seq_state
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam logic [COUNT_WIDTH-1:0] STAGE_LAST = COUNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_STAGES - 1);

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_RAMP     = 2'd2;
    localparam logic [1:0] ST_ON       = 2'd3;

    if (NUM_STAGES < 2 || NUM_STAGES > 8 || STAGE_DELAY < 1 || DOWN_DELAY < 1
        || longint'(STAGE_DELAY) >= (longint'(1) << COUNT_WIDTH)
        || longint'(DOWN_DELAY) >= (longint'(1) << COUNT_WIDTH)) begin : g_bad_cfg
        $error("reset_sequencer: parameter out of range");
    end

`ifdef RST_SEQ_REVERSE_EN
    localparam logic [COUNT_WIDTH-1:0] DOWN_LAST = COUNT_WIDTH'(DOWN_DELAY - 1);
    typedef enum logic [2:0] {S_OFF, S_DEBOUNCE, S_RAMP, S_ON, S_DOWN} state_t;
`else
    typedef enum logic [1:0] {S_OFF, S_DEBOUNCE, S_RAMP, S_ON} state_t;
`endif

    state_t                 state;
    logic                   pg_meta;
    logic                   pg_s;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]       idx;
    logic                   abort;

    assign abort = !pg_s || force_rst;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            pg_meta   <= 1'b0;
            pg_s      <= 1'b0;
            state     <= S_OFF;
            cnt       <= '0;
            idx       <= '0;
            rst_out_l <= '0;
            seq_done  <= 1'b0;
            seq_state <= ST_OFF;
        end else begin
            pg_meta <= pwr_good;
            pg_s    <= pg_meta;
            case (state)
                S_OFF: begin
                    rst_out_l <= '0;
                    seq_done  <= 1'b0;
                    seq_state <= ST_OFF;
                    cnt       <= '0;
                    idx       <= '0;
                    if (!abort) begin
                        // The cycle pg_s is first seen high already counts as one stable cycle.
                        if (STAGE_LAST == '0) begin
                            rst_out_l <= NUM_STAGES'(1);
                            idx       <= IDX_W'(1);
                            state     <= S_RAMP;
                            seq_state <= ST_RAMP;
                        end else begin
                            cnt       <= COUNT_WIDTH'(1);
                            state     <= S_DEBOUNCE;
                            seq_state <= ST_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (abort) begin
                        rst_out_l <= '0;
                        cnt       <= '0;
                        state     <= S_OFF;
                        seq_state <= ST_OFF;
                    end else if (cnt == STAGE_LAST) begin
                        rst_out_l[0] <= 1'b1;
                        cnt          <= '0;
                        idx          <= IDX_W'(1);
                        state        <= S_RAMP;
                        seq_state    <= ST_RAMP;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_RAMP: begin
                    if (abort) begin
                        rst_out_l <= '0;
                        cnt       <= '0;
                        idx       <= '0;
                        state     <= S_OFF;
                        seq_state <= ST_OFF;
                    end else if (cnt == STAGE_LAST) begin
                        rst_out_l[idx] <= 1'b1;
                        cnt            <= '0;
                        if (idx == LAST_IDX) begin
                            state     <= S_ON;
                            seq_done  <= 1'b1;
                            seq_state <= ST_ON;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_ON: begin
`ifdef RST_SEQ_REVERSE_EN
                    if (abort) begin
                        rst_out_l[NUM_STAGES-1] <= 1'b0;
                        seq_done                <= 1'b0;
                        seq_state               <= ST_OFF;
                        cnt                     <= '0;
                        idx                     <= IDX_W'(NUM_STAGES - 2);
                        state                   <= S_DOWN;
                    end
`else
                    if (abort) begin
                        rst_out_l <= '0;
                        seq_done  <= 1'b0;
                        seq_state <= ST_OFF;
                        cnt       <= '0;
                        idx       <= '0;
                        state     <= S_OFF;
                    end
`endif
                end
`ifdef RST_SEQ_REVERSE_EN
                S_DOWN: begin
                    // Shutdown always runs to completion; pg_s and force_rst are ignored here.
                    if (cnt == DOWN_LAST) begin
                        rst_out_l[idx] <= 1'b0;
                        cnt            <= '0;
                        if (idx == '0) begin
                            state <= S_OFF;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
`endif
                default: begin
                    rst_out_l <= '0;
                    seq_done  <= 1'b0;
                    seq_state <= ST_OFF;
                    cnt       <= '0;
                    idx       <= '0;
                    state     <= S_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed test-plan scenarios plus random power-good/force/reset traffic against a stage-count reference model.
module tb_reset_sequencer;

    localparam int N  = 3;
    localparam int CW = 8;
    localparam int SD = 10;
    localparam int DD = 4;

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic         pwr_good = 1'b0;
    logic         force_rst = 1'b0;
    logic [N-1:0] rst_out_l;
    logic         seq_done;
    logic [1:0]   seq_state;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES (N),
        .COUNT_WIDTH(CW),
        .STAGE_DELAY(SD),
        .DOWN_DELAY (DD)
    ) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .pwr_good (pwr_good),
        .force_rst(force_rst),
        .rst_out_l(rst_out_l),
        .seq_done (seq_done),
        .seq_state(seq_state)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int base   = 0;

    // Model: mode 0 idle, 1 powering up, 2 on, 3 shutting down (reverse only).
    // m_t counts consecutive stable power-good cycles; released stages = m_t / SD.
    int m_mode = 0;
    int m_t    = 0;
    int m_rel  = 0;
    int m_d    = 0;
    bit m_p1   = 1'b0;
    bit m_p2   = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc - base, got, exp);
        end
    endtask

    task automatic model_edge();
        bit ab;
        if (!rst_l) begin
            m_mode = 0; m_t = 0; m_rel = 0; m_d = 0; m_p1 = 1'b0; m_p2 = 1'b0;
            return;
        end
        ab = !m_p2 || force_rst;
        case (m_mode)
            0: if (!ab) begin m_mode = 1; m_t = 1; end
            1: if (ab) m_mode = 0; else m_t++;
            2: if (ab) begin
`ifdef RST_SEQ_REVERSE_EN
                   m_mode = 3; m_d = 0;
`else
                   m_mode = 0;
`endif
               end
            default: m_d++;
        endcase
        if (m_mode == 1) begin
            m_rel = (m_t / SD > N) ? N : m_t / SD;
            if (m_rel == N) m_mode = 2;
        end
`ifdef RST_SEQ_REVERSE_EN
        if (m_mode == 3) begin
            m_rel = N - 1 - m_d / DD;
            if (m_rel <= 0) begin m_rel = 0; m_mode = 0; end
        end
`endif
        if (m_mode == 0) m_rel = 0;
        if (m_mode == 2) m_rel = N;
        m_p2 = m_p1;
        m_p1 = pwr_good;
    endtask

    task automatic step();
        int st;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        st = (m_mode == 0 || m_mode == 3) ? 0 : (m_mode == 2) ? 3 : (m_rel == 0) ? 1 : 2;
        chk("model_rst_out_l", 8'(rst_out_l), 8'((1 << m_rel) - 1));
        chk("model_seq_done", 8'(seq_done), 8'(m_mode == 2));
        chk("model_seq_state", 8'(seq_state), 8'(st));
    endtask

    task automatic run_until(input int rel);
        while (cyc < base + rel) step();
    endtask

    task automatic do_reset();
        rst_l = 1'b0; force_rst = 1'b0; pwr_good = 1'b0;
        step();
        step();
        rst_l = 1'b1;
        base = cyc;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("reset_rst_out_l", 8'(rst_out_l), 8'h00);
        chk("reset_seq_done", 8'(seq_done), 8'h0);
        chk("reset_seq_state", 8'(seq_state), 8'h0);

        // Power-up then shutdown
        pwr_good = 1'b1;
        run_until(11); chk("pu_before_s0", 8'(rst_out_l), 8'h0);
        run_until(12); chk("pu_s0", 8'(rst_out_l), 8'h1);
        chk("pu_state_ramp", 8'(seq_state), 8'h2);
        run_until(21); chk("pu_before_s1", 8'(rst_out_l), 8'h1);
        run_until(22); chk("pu_s1", 8'(rst_out_l), 8'h3);
        run_until(32); chk("pu_s2", 8'(rst_out_l), 8'h7);
        chk("pu_done", 8'(seq_done), 8'h1);
        chk("pu_state_on", 8'(seq_state), 8'h3);
        run_until(50); pwr_good = 1'b0;
        run_until(52); chk("sd_hold", 8'(rst_out_l), 8'h7);
        run_until(53); chk("sd_done_low", 8'(seq_done), 8'h0);
`ifdef RST_SEQ_REVERSE_EN
        chk("sd_rev_53", 8'(rst_out_l), 8'h3);
        run_until(56); chk("sd_rev_56", 8'(rst_out_l), 8'h3);
        run_until(57); chk("sd_rev_57", 8'(rst_out_l), 8'h1);
        run_until(61); chk("sd_rev_61", 8'(rst_out_l), 8'h0);
`else
        chk("sd_all_53", 8'(rst_out_l), 8'h0);
`endif

        // Glitch on power-good
        do_reset();
        pwr_good = 1'b1;
        run_until(6); pwr_good = 1'b0;
        run_until(20); pwr_good = 1'b1;
        run_until(31); chk("glitch_no_early", 8'(rst_out_l), 8'h0);
        run_until(32); chk("glitch_s0", 8'(rst_out_l), 8'h1);

        // Abort in RAMP via force_rst
        do_reset();
        pwr_good = 1'b1;
        run_until(25); force_rst = 1'b1;
        run_until(26); chk("abort_out", 8'(rst_out_l), 8'h0);
        chk("abort_state", 8'(seq_state), 8'h0);
        run_until(30); force_rst = 1'b0;
        run_until(39); chk("abort_no_early", 8'(rst_out_l), 8'h0);
        run_until(40); chk("abort_restart_s0", 8'(rst_out_l), 8'h1);

        // Mid-sequence synchronous reset
        do_reset();
        pwr_good = 1'b1;
        run_until(24); rst_l = 1'b0;
        run_until(25); chk("midrst_out", 8'(rst_out_l), 8'h0);
        chk("midrst_state", 8'(seq_state), 8'h0);
        run_until(27); rst_l = 1'b1;
        run_until(38); chk("midrst_no_early", 8'(rst_out_l), 8'h0);
        run_until(39); chk("midrst_s0", 8'(rst_out_l), 8'h1);

        // force_rst held while power-good rises
        do_reset();
        pwr_good = 1'b1; force_rst = 1'b1;
        run_until(40); chk("simul_state_off", 8'(seq_state), 8'h0);
        force_rst = 1'b0;
        run_until(49); chk("simul_no_early", 8'(rst_out_l), 8'h0);
        run_until(50); chk("simul_s0", 8'(rst_out_l), 8'h1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) pwr_good = ~pwr_good;
            force_rst = ($urandom_range(0, 119) == 0);
            rst_l = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Multi-stage power-on reset controller for the CPLD. It waits for a debounced power-good indication, then releases NUM_STAGES active-low reset outputs one at a time, with a programmable delay between stages. On power loss or a forced-reset request it re-asserts them, either in reverse order or all at once. It sits between the board power-good/I2C control logic and the downstream reset pins, and replaces ad-hoc per-pin delay counters.

## Interface

Parameters:

- NUM_STAGES, 4: number of sequenced reset outputs (2..8).
- COUNT_WIDTH, 24: width of the shared delay counter.
- STAGE_DELAY, 5000000: cycles of stable power-good before stage 0 release, and between consecutive releases (100 ms at 50 MHz). Must satisfy 1 ≤ STAGE_DELAY ≤ 2^COUNT_WIDTH−1.
- DOWN_DELAY, 50000: cycles between stage assertions during reverse shutdown (1 ms). Same range rule as STAGE_DELAY.

Ports:

- clk  input  1  system clock; all logic is on its rising edge.
- rst_l  input  1  reset, synchronous and active-low.
- pwr_good  input  1  asynchronous board power-good; synchronized internally with 2 flops.
- force_rst  input  1  synchronous request to put all stages in reset; level-sensitive.
- rst_out_l  output  NUM_STAGES  per-stage reset; 0 means asserted; registered.
- seq_done  output  1  high only in state ON; registered.
- seq_state  output  2  current state encoding: OFF=0, DEBOUNCE=1, RAMP=2, ON=3 (DOWN reports 0 when enabled).

## Operation

- Reset (rst_l=0 at a clk edge):
  - rst_out_l=all 0, seq_done=0, seq_state=0.
  - Counter=0, stage index=0, synchronizer flops=0.
- pg_s is the 2-flop synchronized pwr_good.
- OFF:
  - All outputs asserted, counter=0.
  - Go to DEBOUNCE when pg_s=1 and force_rst=0.
- DEBOUNCE:
  - Counter increments while pg_s=1.
  - pg_s=0 or force_rst=1: go to OFF, counter=0.
  - When counter reaches STAGE_DELAY−1: release rst_out_l[0], counter=0, index=1, go to RAMP.
- RAMP:
  - Counter increments each cycle.
  - At STAGE_DELAY−1: release rst_out_l[index], index++, counter=0.
  - After releasing index NUM_STAGES−1: go to ON.
  - Abort on pg_s=0 or force_rst=1: all rst_out_l asserted on the next edge, go to OFF. This applies regardless of configuration.
- ON:
  - seq_done=1, all rst_out_l=1.
  - pg_s=0 or force_rst=1: shutdown behaviour per Configuration.
- Release order is fixed: stage 0 first, ascending. Exactly one bit changes per release event.
- Counter saturates; it never wraps. Comparison is unsigned at COUNT_WIDTH bits.
- Simultaneous events:
  - force_rst and pg_s rising in the same cycle: stay in OFF.
  - Abort in the same cycle as a release: the abort wins and the release is not performed.

## Timing

- pwr_good rising to pg_s high: 2 cycles.
- pg_s high to rst_out_l[0] release: STAGE_DELAY cycles.
- rst_out_l[k] release: 2 + (k+1)·STAGE_DELAY cycles after pwr_good first sampled high.
- seq_done rises on the same edge as rst_out_l[NUM_STAGES−1].
- Abort or immediate shutdown: all rst_out_l low and seq_done low 1 cycle after pg_s=0 or force_rst=1 is sampled. From the pwr_good pin this is 3 cycles.
- rst_l has priority over every event and takes effect at the next edge, including mid-RAMP or mid-DOWN.

## Configuration

- RST_SEQ_REVERSE_EN defined:
  - ON exits to DOWN.
  - On entry, rst_out_l[NUM_STAGES−1] is asserted and seq_done goes low.
  - Each subsequent DOWN_DELAY cycles, the next lower stage is asserted.
  - After stage 0 is asserted, go to OFF.
  - force_rst or pg_s returning mid-DOWN does not cancel the shutdown.
  - A rising pg_s is ignored until OFF is reached.
- RST_SEQ_REVERSE_EN undefined:
  - ON exits directly to OFF, asserting all stages on one edge.
  - DOWN_DELAY is unused and the DOWN state is not built.

## Test plan

- Power-up (NUM_STAGES=3, STAGE_DELAY=10), pwr_good raised at cycle 0 → rst_out_l[0] releases at cycle 12, [1] at 22, [2] at 32; seq_done=1 at cycle 32; seq_state=3.
- Glitch: pwr_good high for 6 cycles then low, then high again at cycle 20 → no release before cycle 32; first release at cycle 32.
- Abort in RAMP: force_rst=1 at cycle 25 → rst_out_l=3'b000 at cycle 26, seq_state=0; release restarts only after force_rst=0.
- Shutdown with RST_SEQ_REVERSE_EN (DOWN_DELAY=4), pwr_good dropped in ON at cycle 50 → rst_out_l=3'b011 at cycle 53, 3'b001 at 57, 3'b000 at 61; seq_done=0 at 53. Without the macro → 3'b000 at cycle 53.
- Mid-sequence reset: rst_l=0 at cycle 24 → all outputs 0 and seq_state=0 at next edge; the counter restarts from 0 after rst_l returns high.
- Simultaneous: pwr_good rises with force_rst=1 held 40 cycles → stays OFF, with no release until STAGE_DELAY cycles after force_rst drops.
